hex_display_ctrl: RTL
=====================

Name: hex_display_ctrl

Overview:
- Avalon-MM slave controller that owns the six-digit seven-segment display (HEX0..HEX5) of the embedded system.
- The processor writes a 24-bit value plus control settings. The block drives all six active-low segment buses.
- It sequences optional blinking, nibble scrolling and leading-zero blanking from a free-running prescaled tick.
- Replaces a direct PIO-to-decoder path; sits between the interconnect and the board pins.

Parameters:
- PRESCALE, 50000, clk cycles per tick (1 kHz at 50 MHz); must be >= 2
- PERIOD_RST, 250, reset value of PERIOD register (ticks per blink/scroll step)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- address  in  2  Avalon word address
- write  in  1  Avalon write strobe
- writedata  in  32  Avalon write data
- read  in  1  Avalon read strobe
- readdata  out  32  Avalon read data, latency 1
- hex0..hex5  out  7 each  segments {g,f,e,d,c,b,a}, active-low; hex0 = least significant digit

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset. Everything below is evaluated on the rising edge of clk.
- Register map:
  - 0 VALUE [23:0] RW
  - 1 CTRL RW: bit0 EN, bit1 BLINK, bit2 SCROLL, bit3 LZB
  - 2 MASK [5:0] RW, digits affected by blink
  - 3 PERIOD [7:0] RW
  - Unused bits read 0 and ignore writes.
- Reset:
  - VALUE=0, CTRL=0, MASK=0, PERIOD=PERIOD_RST, readdata=0
  - Image register=0, counters=0, phase=0
  - All hexN=7'h7F (blank)
- Reads: readdata is valid the cycle after read=1 and holds until the next read. Write and read in the same cycle to the same address: readdata returns the old value.
- Tick generator: prescale counter runs 0..PRESCALE-1 only while EN=1. tick=1 for one cycle at wrap.
- Step counter:
  - Counts ticks 0..P-1, where P = PERIOD, or 1 if PERIOD=0.
  - step=1 on the tick that wraps it.
- FSM states:
  - OFF: EN=0. All outputs blank, counters held at 0.
  - LOAD: one cycle. Image <= VALUE, phase <= 0, counters cleared.
  - RUN: processes steps.
- FSM transitions:
  - OFF -> LOAD when EN becomes 1.
  - RUN -> LOAD on any write to VALUE or CTRL.
  - Any state -> OFF when EN=0.
  - LOAD -> RUN unconditionally.
- In RUN, on each step:
  - Phase toggles if BLINK=1; otherwise phase=0.
  - If SCROLL=1, image rotates left one nibble: image <= {image[19:0], image[23:20]}.
- Simultaneous events: a VALUE/CTRL write in the same cycle as a step wins. The step is discarded and LOAD follows. MASK/PERIOD writes take effect immediately and do not reload. PERIOD lowered below the current count: the counter wraps at the next tick.
- Output pipeline: one registered stage from image/phase/control to hexN. Latency from a VALUE write to visible segments: write cycle + LOAD + 1 register = hexN updates 3 cycles after the write edge.
- Per-digit blanking: digit i is blank (7'h7F) if any of the following holds:
  - EN=0
  - BLINK=1 and phase=1 and MASK[i]=1
  - LZB=1, i>0, and image nibbles i..5 are all zero. Digit 0 always shows, so 0 displays "0".
- Otherwise digit i = standard hex decode (0-F) of image nibble i.
- Reset asserted mid-operation: all state returns to reset values at that edge. Outputs are blank on the following cycle.

Decomposition:
- Package hex_display_pkg:
  - Address constants ADDR_VALUE/ADDR_CTRL/ADDR_MASK/ADDR_PERIOD
  - CTRL bit indices
  - SEG_BLANK = 7'h7F
  - FSM state encoding (OFF/LOAD/RUN)
- Sub-module: reuse the existing combinational hex7seg decoder, instantiated six times. Blanking is muxed after the decoder, inside hex_display_ctrl.

Test Plan (PRESCALE=4, PERIOD written as 2 unless noted):
- Reset, then write VALUE=24'h123456, CTRL=1 -> 3 cycles later hex5..hex0 = 1,2,3,4,5,6 (hex0 = 7'h02 for "6"); readback addr0 = 0x00123456.
- CTRL=0x9 (EN+LZB), VALUE=24'h00000A -> hex0 = "A" (7'h08), hex1..hex5 = 7'h7F. VALUE=0 -> hex0 = "0" (7'h40), rest blank.
- CTRL=0x3, MASK=6'b000011, VALUE=24'h123456 -> digits 0-1 alternate between decoded and 7'h7F every 8 cycles; digits 2-5 stay steady.
- CTRL=0x5, VALUE=24'h123456 -> after 8 cycles the display reads 234561; after 48 cycles it reads 123456 again. A VALUE write coinciding with a step -> image = new value, no rotation that step.
- PERIOD=0 -> step every tick (4 cycles). Clearing EN mid-scroll -> outputs blank next cycle. Re-setting EN -> display restarts from VALUE, not the rotated image.
- Assert reset during RUN with blink phase=1 -> all hexN = 7'h7F and registers read back reset values (PERIOD = 250).

Source files
------------

// File: rtl/hex_display_pkg.sv
// Shared definitions for the six-digit seven-segment display controller.
//   - Avalon word addresses of the four registers
//   - bit positions inside CTRL
//   - blank segment pattern (active-low, all segments off)
//   - sequencing FSM state encoding
package hex_display_pkg;

  localparam logic [1:0] ADDR_VALUE  = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_MASK   = 2'd2;
  localparam logic [1:0] ADDR_PERIOD = 2'd3;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_BLINK  = 1;
  localparam int unsigned CTRL_SCROLL = 2;
  localparam int unsigned CTRL_LZB    = 3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    StOff,
    StLoad,
    StRun
  } state_e;

endpackage

// File: rtl/hex7seg.sv
// Combinational hex-to-seven-segment decoder.
//   hex_i : 4-bit value 0..F
//   seg_o : segments {g,f,e,d,c,b,a}, active-low
module hex7seg (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    case (hex_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// Avalon-MM slave driving six active-low seven-segment digits.
// Registers: VALUE (24b), CTRL {LZB,SCROLL,BLINK,EN}, MASK (6b), PERIOD (8b).
// A prescaled tick feeds a step counter; each step toggles the blink phase and/or
// rotates the displayed image by one nibble. Segment outputs are registered once.
//   clk, reset          : clock, synchronous active-high reset
//   address/write/...   : Avalon-MM slave, read latency 1
//   hex0..hex5          : segments {g,f,e,d,c,b,a}, hex0 = least significant digit
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int unsigned PRESCALE   = 50000,
  parameter int unsigned PERIOD_RST = 250
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5
);

  localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  state_e           state_q, state_d;
  logic [23:0]      value_q, value_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [5:0]       mask_q, mask_d;
  logic [7:0]       period_q, period_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [23:0]      image_q, image_d;
  logic             phase_q, phase_d;
  logic [PreW-1:0]  pre_q, pre_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [5:0][6:0]  seg_q, seg_d;
  logic [5:0][6:0]  dec;

  logic        wr_reload;
  logic        tick;
  logic        step;
  logic [7:0]  period_eff;
  logic [31:0] rdata_sel;
  logic        unused_wdata;

  assign unused_wdata = ^writedata[31:24];

  // Register file writes; unused bits are dropped.
  always_comb begin
    value_d  = value_q;
    ctrl_d   = ctrl_q;
    mask_d   = mask_q;
    period_d = period_q;
    if (write) begin
      case (address)
        ADDR_VALUE:  value_d  = writedata[23:0];
        ADDR_CTRL:   ctrl_d   = writedata[3:0];
        ADDR_MASK:   mask_d   = writedata[5:0];
        ADDR_PERIOD: period_d = writedata[7:0];
        default:     value_d  = value_q;
      endcase
    end
  end

  // Read mux uses pre-write register values so a same-cycle write returns old data.
  always_comb begin
    rdata_sel = '0;
    case (address)
      ADDR_VALUE:  rdata_sel = {8'd0, value_q};
      ADDR_CTRL:   rdata_sel = {28'd0, ctrl_q};
      ADDR_MASK:   rdata_sel = {26'd0, mask_q};
      ADDR_PERIOD: rdata_sel = {24'd0, period_q};
      default:     rdata_sel = '0;
    endcase
    rdata_d = read ? rdata_sel : rdata_q;
  end

  assign wr_reload = write && ((address == ADDR_VALUE) || (address == ADDR_CTRL));

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StOff;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. EN is taken from the post-write value so enabling, disabling
  // and reloading all act on the edge that accepts the CTRL/VALUE write.
  always_comb begin
    state_d = state_q;
    if (!ctrl_d[CTRL_EN]) begin
      state_d = StOff;
    end else if (wr_reload) begin
      state_d = StLoad;
    end else begin
      unique case (state_q)
        StOff:   state_d = StLoad;
        StLoad:  state_d = StRun;
        StRun:   state_d = StRun;
        default: state_d = StOff;
      endcase
    end
  end

  assign period_eff = (period_q == 8'd0) ? 8'd1 : period_q;
  assign tick       = (state_q == StRun) && (pre_q == PreW'(PRESCALE - 1));
  // ">=" so a PERIOD lowered below the current count wraps on the next tick.
  assign step       = tick && (cnt_q >= (period_eff - 8'd1));

  // Counters only run in RUN; OFF and LOAD hold them at zero.
  always_comb begin
    pre_d   = '0;
    cnt_d   = '0;
    image_d = image_q;
    phase_d = phase_q;
    unique case (state_q)
      StLoad: begin
        image_d = value_q;
        phase_d = 1'b0;
      end
      StRun: begin
        pre_d = tick ? '0 : pre_q + PreW'(1);
        if (tick) begin
          cnt_d = step ? 8'd0 : cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q;
        end
        // A concurrent VALUE/CTRL write forces LOAD; that step is discarded.
        if (step && !wr_reload) begin
          phase_d = ctrl_q[CTRL_BLINK] ? ~phase_q : 1'b0;
          if (ctrl_q[CTRL_SCROLL]) begin
            image_d = {image_q[19:0], image_q[23:20]};
          end
        end
      end
      default: begin
        pre_d = '0;
      end
    endcase
  end

  for (genvar g = 0; g < 6; g++) begin : g_dec
    hex7seg u_hex7seg (
      .hex_i (image_q[4*g +: 4]),
      .seg_o (dec[g])
    );
  end

  // FSM/output: per-digit blanking after the decoders.
  always_comb begin
    seg_d = '0;
    for (int i = 0; i < 6; i++) begin
      if (!ctrl_q[CTRL_EN] ||
          (ctrl_q[CTRL_BLINK] && phase_q && mask_q[i]) ||
          (ctrl_q[CTRL_LZB] && (i != 0) && ((image_q >> (4 * i)) == 24'd0))) begin
        seg_d[i] = SEG_BLANK;
      end else begin
        seg_d[i] = dec[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q  <= '0;
      ctrl_q   <= '0;
      mask_q   <= '0;
      period_q <= 8'(PERIOD_RST);
      rdata_q  <= '0;
      image_q  <= '0;
      phase_q  <= 1'b0;
      pre_q    <= '0;
      cnt_q    <= '0;
      seg_q    <= {6{SEG_BLANK}};
    end else begin
      value_q  <= value_d;
      ctrl_q   <= ctrl_d;
      mask_q   <= mask_d;
      period_q <= period_d;
      rdata_q  <= rdata_d;
      image_q  <= image_d;
      phase_q  <= phase_d;
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      seg_q    <= seg_d;
    end
  end

  assign readdata = rdata_q;
  assign hex0     = seg_q[0];
  assign hex1     = seg_q[1];
  assign hex2     = seg_q[2];
  assign hex3     = seg_q[3];
  assign hex4     = seg_q[4];
  assign hex5     = seg_q[5];

endmodule
